// File: rtl/inst_queue.sv
// Instruction queue between fetch and dual-issue decode: circular buffer of {pc, inst} pairs.
// Optional INST_QUEUE_PERF_EN adds single/dual issue cycle counters (perf_single, perf_dual).

`ifndef SINGLE_ISSUE
`define SINGLE_ISSUE 2'd1
`endif
`ifndef DUAL_ISSUE
`define DUAL_ISSUE 2'd2
`endif

module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic [1:0]       fetch_num,
    input  logic [31:0]      fetch_pc1,
    input  logic [31:0]      fetch_inst1,
    input  logic [31:0]      fetch_pc2,
    input  logic [31:0]      fetch_inst2,
    output logic             fetch_ready,
    output logic             inst1_valid,
    output logic             inst2_valid,
    output logic [31:0]      inst1_pc,
    output logic [31:0]      inst1,
    output logic [31:0]      inst2_pc,
    output logic [31:0]      inst2,
    input  logic             issue_en,
    input  logic [1:0]       issue_mode,
    output logic [PTR_W:0]   count
`ifdef INST_QUEUE_PERF_EN
    ,
    output logic [31:0]      perf_single,
    output logic [31:0]      perf_dual
`endif
);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [1:0]       push_n, pop_n;
    logic [PTR_W-1:0] wr_ptr_nx, rd_ptr_nx;
    logic [63:0]      head1, head2;

    assign fetch_ready = (cnt_q <= (PTR_W+1)'(DEPTH - 2));
    assign inst1_valid = (cnt_q != '0);
    assign inst2_valid = (cnt_q > (PTR_W+1)'(1));
    assign count       = cnt_q;

    assign wr_ptr_nx = wr_ptr_q + 1'b1;
    assign rd_ptr_nx = rd_ptr_q + 1'b1;

    always_comb begin
        push_n = 2'd0;
        pop_n  = 2'd0;
        if (resetn && !flush) begin
            if (fetch_ready && fetch_num != 2'd0)
                push_n = (fetch_num == 2'd1) ? 2'd1 : 2'd2;
            // A non-dual mode, or dual with only one entry present, retires one.
            if (issue_en && inst1_valid)
                pop_n = (issue_mode == `DUAL_ISSUE && inst2_valid) ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        cnt_d    = cnt_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        if (!resetn || flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0)
            mem_q[wr_ptr_q] <= {fetch_pc1, fetch_inst1};
        if (push_n == 2'd2)
            mem_q[wr_ptr_nx] <= {fetch_pc2, fetch_inst2};
    end

    assign head1 = mem_q[rd_ptr_q];
    assign head2 = mem_q[rd_ptr_nx];

    always_comb begin
        inst1_pc = '0;
        inst1    = '0;
        inst2_pc = '0;
        inst2    = '0;
        if (inst1_valid) begin
            inst1_pc = head1[63:32];
            inst1    = head1[31:0];
        end
        if (inst2_valid) begin
            inst2_pc = head2[63:32];
            inst2    = head2[31:0];
        end
    end

`ifdef INST_QUEUE_PERF_EN
    logic [31:0] perf_single_q, perf_single_d;
    logic [31:0] perf_dual_q, perf_dual_d;

    // Cleared by reset only; a flush keeps the history.
    always_comb begin
        perf_single_d = perf_single_q + ((pop_n == 2'd1) ? 32'd1 : 32'd0);
        perf_dual_d   = perf_dual_q   + ((pop_n == 2'd2) ? 32'd1 : 32'd0);
        if (!resetn) begin
            perf_single_d = '0;
            perf_dual_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        perf_single_q <= perf_single_d;
        perf_dual_q   <= perf_dual_d;
    end

    assign perf_single = perf_single_q;
    assign perf_dual   = perf_dual_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH 16); perf checks built only with INST_QUEUE_PERF_EN.

`ifndef SINGLE_ISSUE
`define SINGLE_ISSUE 2'd1
`endif
`ifndef DUAL_ISSUE
`define DUAL_ISSUE 2'd2
`endif

module tb_inst_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [1:0]  fetch_num;
    logic [31:0] fetch_pc1, fetch_inst1, fetch_pc2, fetch_inst2;
    logic        fetch_ready;
    logic        inst1_valid, inst2_valid;
    logic [31:0] inst1_pc, inst1, inst2_pc, inst2;
    logic        issue_en;
    logic [1:0]  issue_mode;
    logic [4:0]  count;
`ifdef INST_QUEUE_PERF_EN
    logic [31:0] perf_single, perf_dual;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .fetch_num(fetch_num),
        .fetch_pc1(fetch_pc1), .fetch_inst1(fetch_inst1),
        .fetch_pc2(fetch_pc2), .fetch_inst2(fetch_inst2),
        .fetch_ready(fetch_ready), .inst1_valid(inst1_valid), .inst2_valid(inst2_valid),
        .inst1_pc(inst1_pc), .inst1(inst1), .inst2_pc(inst2_pc), .inst2(inst2),
        .issue_en(issue_en), .issue_mode(issue_mode), .count(count)
`ifdef INST_QUEUE_PERF_EN
        , .perf_single(perf_single), .perf_dual(perf_dual)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] n, input logic [31:0] pc);
        fetch_num   = n;
        fetch_pc1   = pc;
        fetch_inst1 = ~pc;
        fetch_pc2   = pc + 32'd4;
        fetch_inst2 = ~(pc + 32'd4);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; issue_en = 1'b0; issue_mode = `SINGLE_ISSUE;
        offer(2'd0, 32'h0);
        cyc(); cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_v1", 32'(inst1_valid), 32'd0);
        chk("rst_v2", 32'(inst2_valid), 32'd0);
        chk("rst_inst1", inst1, 32'd0);
        chk("rst_inst2", inst2, 32'd0);
        resetn = 1'b1;
        cyc();
        chk("idle_count", 32'(count), 32'd0);
        $display("txn reset/idle done");

        // Dual issue of a freshly fetched pair
        fetch_num = 2'd2;
        fetch_pc1 = 32'hBFC00000; fetch_inst1 = 32'h24010001;
        fetch_pc2 = 32'hBFC00004; fetch_inst2 = 32'h24020002;
        cyc();
        fetch_num = 2'd0;
        chk("dual_count2", 32'(count), 32'd2);
        chk("dual_v1", 32'(inst1_valid), 32'd1);
        chk("dual_v2", 32'(inst2_valid), 32'd1);
        chk("dual_pc1", inst1_pc, 32'hBFC00000);
        chk("dual_inst1", inst1, 32'h24010001);
        chk("dual_pc2", inst2_pc, 32'hBFC00004);
        chk("dual_inst2", inst2, 32'h24020002);
        issue_en = 1'b1; issue_mode = `DUAL_ISSUE;
        cyc();
        issue_en = 1'b0;
        chk("dual_count0", 32'(count), 32'd0);
        chk("dual_v1_after", 32'(inst1_valid), 32'd0);
        chk("dual_pc1_zero", inst1_pc, 32'd0);
        $display("txn dual issue pair done");

        // Single issue then dual with only one entry left
        fetch_num = 2'd2;
        cyc();
        fetch_num = 2'd0;
        issue_en = 1'b1; issue_mode = `SINGLE_ISSUE;
        cyc();
        chk("single_count1", 32'(count), 32'd1);
        chk("single_pc1", inst1_pc, 32'hBFC00004);
        chk("single_inst1", inst1, 32'h24020002);
        chk("single_v2", 32'(inst2_valid), 32'd0);
        chk("single_pc2_zero", inst2_pc, 32'd0);
        issue_mode = `DUAL_ISSUE;
        cyc();
        issue_en = 1'b0;
        chk("single_dual1_count", 32'(count), 32'd0);
        $display("txn single issue then dual-of-one done");

        // Fill to DEPTH with pairs, wrapping the write pointer
        for (int k = 0; k < 8; k++) begin
            offer(2'd2, 32'h1000 + 32'(8 * k));
            cyc();
            chk("fill_count", 32'(count), 32'(2 * (k + 1)));
            chk("fill_ready", 32'(fetch_ready), (k < 7) ? 32'd1 : 32'd0);
        end
        offer(2'd2, 32'hDEAD0000);
        cyc();
        chk("drop_count", 32'(count), 32'd16);
        offer(2'd0, 32'h0);
        issue_en = 1'b1; issue_mode = `DUAL_ISSUE;
        for (int j = 0; j < 8; j++) begin
            chk("drain_pc1", inst1_pc, 32'h1000 + 32'(8 * j));
            chk("drain_pc2", inst2_pc, 32'h1004 + 32'(8 * j));
            chk("drain_inst2", inst2, ~(32'h1004 + 32'(8 * j)));
            cyc();
        end
        issue_en = 1'b0;
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_ready", 32'(fetch_ready), 32'd1);
        $display("txn fill/drop/drain done");

        // Flush with a simultaneous push at count 5
        offer(2'd2, 32'h2000); cyc();
        offer(2'd2, 32'h2008); cyc();
        offer(2'd1, 32'h2010); cyc();
        chk("pre_flush_count", 32'(count), 32'd5);
        offer(2'd2, 32'h3000);
        flush = 1'b1; issue_en = 1'b1;
        cyc();
        flush = 1'b0; issue_en = 1'b0;
        offer(2'd0, 32'h0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_v1", 32'(inst1_valid), 32'd0);
        chk("flush_v2", 32'(inst2_valid), 32'd0);
        chk("flush_pc1", inst1_pc, 32'd0);
        cyc();
        chk("flush_idle_count", 32'(count), 32'd0);
        offer(2'd1, 32'h4000);
        cyc();
        offer(2'd0, 32'h0);
        chk("post_flush_count", 32'(count), 32'd1);
        chk("post_flush_pc1", inst1_pc, 32'h4000);
        $display("txn flush with push done");

`ifdef INST_QUEUE_PERF_EN
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        chk("perf_rst_single", perf_single, 32'd0);
        chk("perf_rst_dual", perf_dual, 32'd0);
        for (int k = 0; k < 6; k++) begin
            offer(2'd2, 32'h5000 + 32'(8 * k));
            cyc();
        end
        offer(2'd0, 32'h0);
        issue_en = 1'b1; issue_mode = `SINGLE_ISSUE;
        cyc(); cyc(); cyc();
        issue_mode = `DUAL_ISSUE;
        cyc(); cyc(); cyc(); cyc();
        issue_en = 1'b0;
        chk("perf_count", 32'(count), 32'd1);
        chk("perf_single", perf_single, 32'd3);
        chk("perf_dual", perf_dual, 32'd4);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("perf_flush_single", perf_single, 32'd3);
        chk("perf_flush_dual", perf_dual, 32'd4);
        $display("txn perf counters done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between fetch and the dual-issue decode stage. Buffers up to DEPTH fetched {pc, inst} pairs and presents the two oldest entries to decode as slot 1 and slot 2. Each cycle it retires one or two entries according to the issue mode produced by the issue-check logic. A synchronous flush empties it on branch redirect or exception.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 4
- PTR_W, 4, log2(DEPTH)
- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  synchronous reset, active low (`RST_ENABLE`)
- flush  in  1  discard all entries this cycle
- fetch_num  in  2  entries offered this cycle: 0, 1 or 2 (3 treated as 2)
- fetch_pc1, fetch_inst1  in  32, 32  older offered entry
- fetch_pc2, fetch_inst2  in  32, 32  younger offered entry
- fetch_ready  out  1  high when free slots ≥ 2
- inst1_valid, inst2_valid  out  1, 1  head / head+1 entries present
- inst1_pc, inst1, inst2_pc, inst2  out  32 each  head entries; 0 when the matching valid is low
- issue_en  in  1  decode accepts this cycle (low = decode stall)
- issue_mode  in  2  `SINGLE_ISSUE` or `DUAL_ISSUE`
- count  out  PTR_W+1  current occupancy

## Operation
- Storage: circular array of DEPTH × 64 bits, head pointer rd_ptr, tail pointer wr_ptr (PTR_W bits, wrap modulo DEPTH), occupancy cnt (PTR_W+1 bits).
- Push: when fetch_ready && fetch_num ≠ 0 && !flush, write fetch entry 1 at wr_ptr, entry 2 (if fetch_num = 2) at wr_ptr+1; wr_ptr += push_n. When fetch_ready is low, offered entries are dropped; fetch must hold them.
- Pop count pop_n:
  - 0 if !issue_en or !inst1_valid.
  - 1 if issue_mode = `SINGLE_ISSUE`, or `DUAL_ISSUE` with !inst2_valid.
  - 2 if issue_mode = `DUAL_ISSUE` and inst2_valid.
  - rd_ptr += pop_n.
- cnt_next = cnt + push_n − pop_n. Simultaneous push and pop in the same cycle is legal, including at cnt = DEPTH−2 (push 2, pop 0 → full).
- Head outputs are combinational reads at rd_ptr and rd_ptr+1 (wrap); inst1_valid = cnt ≥ 1, inst2_valid = cnt ≥ 2.
- Flush: rd_ptr, wr_ptr and cnt go to 0; the same-cycle push and pop are ignored. Array contents are not cleared.
- Reset (resetn low at edge): same as flush. fetch_ready reads 1, valids 0, data outputs 0, count 0.
- Underflow and overflow are impossible by construction: pop is capped by valids, push is gated by fetch_ready.

## Timing
- Push-to-visible latency: 1 cycle. An entry written at edge N appears on inst1/inst2 after edge N. No empty-queue bypass.
- Pop takes effect at the edge. The next head is visible in the following cycle.
- fetch_ready and valids derive from registered cnt only, so they have no combinational path from fetch_num, issue_en or issue_mode.
- Flush has priority over reset-free operation; reset has priority over flush.

## Configuration
- INST_QUEUE_PERF_EN defined:
  - Adds outputs perf_single[31:0] and perf_dual[31:0].
  - Each counts cycles with pop_n = 1 or pop_n = 2 respectively.
  - Both counters cleared by reset only, not by flush, and wrap at 2^32.
- Undefined: these ports and counters do not exist.

## Test plan
- Reset then idle → count = 0, fetch_ready = 1, inst1_valid = inst2_valid = 0, inst1 = inst2 = 0.
- Push {0xBFC00000, 0x24010001}, {0xBFC00004, 0x24020002} with fetch_num = 2, `DUAL_ISSUE`, issue_en = 1 next cycle → both valid on cycle 1; count 2 → 0 after cycle 1.
- Same two entries with `SINGLE_ISSUE` → first cycle pops 0xBFC00000 only; next cycle inst1_pc = 0xBFC00004, inst2_valid = 0; `DUAL_ISSUE` then pops 1.
- Push 2 per cycle with issue_en = 0 for 8 cycles (DEPTH = 16) → count reaches 16 after 8 pushes, fetch_ready low from count = 15; an extra offer is dropped and count stays 16; then dual pops drain in order with pointer wrap.
- cnt = 5 with push 2 and flush in the same cycle → next cycle count = 0, valids 0, the pushed entries absent.
- With INST_QUEUE_PERF_EN, 3 single-pop and 4 dual-pop cycles → perf_single = 3, perf_dual = 4; a flush leaves both unchanged.
